cp0_exc_unit: RTL and testbench

- Coprocessor-0 register file and exception responder for the pipelined MIPS core.
- Consumes the decoder's exception/CP0 control outputs (ExcCode, cpzWrite/mtc0, mfc0 select, eret) as carried to the M stage, plus external hardware interrupt lines.
- Holds SR(12), Cause(13) and EPC(14), raises a flush/redirect request, and supplies EPC for eret and read data for mfc0.

---
 rtl/cp0_exc_unit.sv | 128 ++++++++++++
 tb/tb_cp0_exc_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// CP0 register file (SR/Cause/EPC) and exception/interrupt responder at the M stage.
// Optional Count/Compare timer is built when CP0_COUNT_EN is defined.
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned HW_INT_W     = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cp0_we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic [31:0]         vpc,
  input  logic                bd_in,
  input  logic [4:0]          exc_code_in,
  input  logic                eret_in,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic                req,
  output logic [31:0]         handler_pc,
  output logic [31:0]         epc_out
);

  typedef enum logic [4:0] {
    A_COUNT   = 5'd9,
    A_COMPARE = 5'd11,
    A_SR      = 5'd12,
    A_CAUSE   = 5'd13,
    A_EPC     = 5'd14
  } cp0_reg_e;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic [5:0]  hw_ext;
  logic [5:0]  ip_lines;
  logic        int_req;
  logic        exc_req;
  logic        mtc0_ok;

  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_W-1:0] = hw_int;
  end

`ifdef CP0_COUNT_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (mtc0_ok && cp0_addr == A_COUNT) count <= cp0_wdata;
      else                                count <= count + 32'd1;
      if (mtc0_ok && cp0_addr == A_COMPARE) begin
        compare    <= cp0_wdata;
        timer_pend <= 1'b0;
      end else if (count == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end

  assign ip_lines = hw_ext | {timer_pend, 5'b0};
`else
  assign ip_lines = hw_ext;
`endif

  assign int_req    = sr_ie & ~sr_exl & (|(ip_lines & sr_im));
  assign exc_req    = ~sr_exl & (exc_code_in != 5'd0);
  // Reset gates the combinational outputs so a held-in-reset core never redirects.
  assign req        = reset & (int_req | exc_req);
  assign mtc0_ok    = reset & cp0_we & ~req;
  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = (mtc0_ok && cp0_addr == A_EPC) ? cp0_wdata : epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= ip_lines;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : exc_code_in;
        cause_bd  <= bd_in;
        epc       <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (mtc0_ok && cp0_addr == A_SR) begin
          sr_im  <= cp0_wdata[15:10];
          sr_exl <= cp0_wdata[1];
          sr_ie  <= cp0_wdata[0];
        end
        if (mtc0_ok && cp0_addr == A_EPC) epc <= cp0_wdata;
        // Placed after the SR write so eret owns EXL if both are asserted.
        if (eret_in) sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_SR:      cp0_rdata = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
      A_CAUSE:   cp0_rdata = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
      A_EPC:     cp0_rdata = epc;
`ifdef CP0_COUNT_EN
      A_COUNT:   cp0_rdata = count;
      A_COMPARE: cp0_rdata = compare;
`endif
      default:   cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed vector table, mid-run reset,
// then randomized cycles against a register-level reference model.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret_in;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_unit #(.HANDLER_ADDR(32'h0000_4180), .HW_INT_W(6)) dut (
    .clk(clk), .reset(reset), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in),
    .exc_code_in(exc_code_in), .eret_in(eret_in), .hw_int(hw_int), .req(req),
    .handler_pc(handler_pc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic        req;
    logic [31:0] rd;
    logic [31:0] eo;
  } vec_t;

  vec_t tv[23];

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                       input logic eret, input logic [5:0] hw);
    cp0_we = we; cp0_addr = addr; cp0_wdata = wd; vpc = pc;
    bd_in = bd; exc_code_in = exc; eret_in = eret; hw_int = hw;
  endtask

  // Checks outputs against the model mid-cycle, then advances the model across the edge.
  task automatic cycle(input bit tab, input logic exp_req, input logic [31:0] exp_rd,
                       input logic [31:0] exp_eo);
    logic [31:0] rd, eo, nsr, ncause, nepc;
    logic ir, er, rq;
    @(negedge clk);
    ir = m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
    er = !m_sr[1] && (exc_code_in != 5'd0);
    rq = ir || er;
    case (cp0_addr)
      5'd12:   rd = m_sr;
      5'd13:   rd = m_cause;
      5'd14:   rd = m_epc;
      default: rd = 32'd0;
    endcase
    eo = (cp0_we && !rq && cp0_addr == 5'd14) ? cp0_wdata : m_epc;
    check32("req", {31'd0, req}, {31'd0, rq});
    check32("rdata", cp0_rdata, rd);
    check32("epc_out", epc_out, eo);
    if (tab) begin
      check32("tab_req", {31'd0, req}, {31'd0, exp_req});
      check32("tab_rdata", cp0_rdata, exp_rd);
      check32("tab_epc_out", epc_out, exp_eo);
    end
    nsr = m_sr;
    nepc = m_epc;
    ncause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
    if (rq) begin
      nsr = nsr | 32'h2;
      ncause = (ncause & 32'h0000_FC00) | ({31'd0, bd_in} << 31)
             | ({27'd0, (ir ? 5'd0 : exc_code_in)} << 2);
      nepc = bd_in ? vpc - 32'd4 : vpc;
    end else begin
      if (cp0_we && cp0_addr == 5'd12) nsr = cp0_wdata & 32'h0000_FC03;
      if (cp0_we && cp0_addr == 5'd14) nepc = cp0_wdata;
      if (eret_in) nsr = nsr & ~32'h2;
    end
    @(posedge clk);
    m_sr = nsr; m_cause = ncause; m_epc = nepc;
    #1;
  endtask

  initial begin
    tv[0]  = '{0, 12, 0, 0, 0, 0, 0, 0,               0, 32'h0,         32'h0};
    tv[1]  = '{0, 14, 0, 32'h3004, 0, 8, 0, 0,        1, 32'h0,         32'h0};
    tv[2]  = '{0, 14, 0, 0, 0, 0, 0, 0,               0, 32'h3004,      32'h3004};
    tv[3]  = '{0, 13, 0, 0, 0, 0, 0, 0,               0, 32'h20,        32'h3004};
    tv[4]  = '{0, 12, 0, 0, 0, 0, 0, 0,               0, 32'h2,         32'h3004};
    tv[5]  = '{0, 12, 0, 0, 0, 0, 1, 0,               0, 32'h2,         32'h3004};
    tv[6]  = '{0, 12, 0, 32'h3020, 1, 10, 0, 0,       1, 32'h0,         32'h3004};
    tv[7]  = '{0, 13, 0, 0, 0, 8, 0, 0,               0, 32'h8000_0028, 32'h301C};
    tv[8]  = '{0, 14, 0, 0, 0, 0, 0, 0,               0, 32'h301C,      32'h301C};
    tv[9]  = '{0, 13, 0, 0, 0, 0, 1, 0,               0, 32'h8000_0028, 32'h301C};
    tv[10] = '{1, 12, 32'h401, 0, 0, 0, 0, 0,         0, 32'h0,         32'h301C};
    tv[11] = '{0, 12, 0, 32'h3040, 0, 0, 0, 1,        1, 32'h401,       32'h301C};
    tv[12] = '{0, 13, 0, 0, 0, 0, 0, 1,               0, 32'h400,       32'h3040};
    tv[13] = '{0, 12, 0, 0, 0, 0, 1, 0,               0, 32'h403,       32'h3040};
    tv[14] = '{1, 14, 32'h5000, 32'h3080, 0, 8, 0, 1, 1, 32'h3040,      32'h3040};
    tv[15] = '{0, 14, 0, 0, 0, 0, 0, 0,               0, 32'h3080,      32'h3080};
    tv[16] = '{0, 13, 0, 0, 0, 0, 1, 0,               0, 32'h0,         32'h3080};
    tv[17] = '{1, 14, 32'h3100, 0, 0, 0, 0, 0,        0, 32'h3080,      32'h3100};
    tv[18] = '{1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,   0, 32'h0,         32'h3100};
    tv[19] = '{1, 12, 32'hFFFF_FFFF, 0, 0, 0, 1, 0,   0, 32'h401,       32'h3100};
    tv[20] = '{0, 12, 0, 0, 0, 0, 0, 0,               0, 32'hFC01,      32'h3100};
    tv[21] = '{0, 14, 0, 32'h3014, 1, 4, 0, 0,        1, 32'h3100,      32'h3100};
    tv[22] = '{0, 13, 0, 0, 0, 0, 0, 0,               0, 32'h8000_0010, 32'h3010};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_sr = '0; m_cause = '0; m_epc = '0;
    #1;
    check32("handler_pc", handler_pc, 32'h0000_4180);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].vpc, tv[i].bd,
            tv[i].exc, tv[i].eret, tv[i].hw);
      cycle(1, tv[i].req, tv[i].rd, tv[i].eo);
    end

    // Asynchronous reset between edges with EXL=1 and EPC=0x3010.
    drive(0, 12, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check32("rst_req", {31'd0, req}, 32'd0);
    for (int a = 12; a <= 14; a++) begin
      cp0_addr = 5'(a);
      #1 check32("rst_rdata", cp0_rdata, 32'd0);
    end
    check32("rst_epc_out", epc_out, 32'd0);
    m_sr = '0; m_cause = '0; m_epc = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // EPC wrap for a delay-slot exception at vpc 0.
    drive(0, 14, 0, 32'h0, 1, 4, 0, 0);
    cycle(1, 1, 32'h0, 32'h0);
    drive(0, 14, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    drive(0, 13, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 32'h8000_0010, 32'hFFFF_FFFC);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      case ($urandom_range(0, 5))
        0: a = 5'd9;
        1: a = 5'd11;
        2: a = 5'd12;
        3: a = 5'd13;
        4: a = 5'd14;
        default: a = 5'($urandom);
      endcase
      drive(($urandom_range(0, 2) == 0), a, $urandom, $urandom, 1'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0,
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0);
      cycle(0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
